// File: rtl/mvp_axi_mem_slave.sv
`timescale 1ns/1ps
// AXI4 INCR burst responder backed by a byte-writable on-chip memory.
// Write and read FSMs run independently; each read beat takes a fetch cycle then a present cycle.
module mvp_axi_mem_slave #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 512,
  parameter int unsigned MEM_DEPTH      = 1024
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  // write address
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [7:0]                    s_axi_awlen,
  // write data
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  input  logic [AXI_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                          s_axi_wlast,
  // write response
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  output logic [1:0]                    s_axi_bresp,
  // read address
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [7:0]                    s_axi_arlen,
  // read data
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  output logic [AXI_DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rlast
);

  localparam int unsigned StrbW = AXI_DATA_WIDTH / 8;
  localparam int unsigned IdxW  = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {WIdle, WData, WResp} wr_st_e;
  typedef enum logic [1:0] {RIdle, RFetch, RData} rd_st_e;

  logic [AXI_DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  wr_st_e            wr_st_q;
  logic [IdxW-1:0]   widx_q;
  logic [7:0]        wcnt_q;
  logic              werr_q;
  logic              awready_q, wready_q, bvalid_q;
  logic [1:0]        bresp_q;

  rd_st_e                    rd_st_q;
  logic [IdxW-1:0]           ridx_q;
  logic [7:0]                rcnt_q;
  logic                      arready_q, rvalid_q, rlast_q;
  logic [AXI_DATA_WIDTH-1:0] rdata_q;

  logic wr_beat;
  logic unused_addr_bits;

  assign wr_beat = (wr_st_q == WData) && s_axi_wvalid;

  // Offset bits and aliased upper bits do not select a word.
  assign unused_addr_bits = ^{s_axi_awaddr[AXI_ADDR_WIDTH-1:6+IdxW], s_axi_awaddr[5:0],
                              s_axi_araddr[AXI_ADDR_WIDTH-1:6+IdxW], s_axi_araddr[5:0]};

  // Write FSM
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_st_q   <= WIdle;
      widx_q    <= '0;
      wcnt_q    <= '0;
      werr_q    <= 1'b0;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
    end else begin
      unique case (wr_st_q)
        WIdle: begin
          if (s_axi_awvalid) begin
            widx_q    <= s_axi_awaddr[6 +: IdxW];
            wcnt_q    <= s_axi_awlen;
            werr_q    <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            wr_st_q   <= WData;
          end
        end
        WData: begin
          if (s_axi_wvalid) begin
            widx_q <= widx_q + 1'b1;
            if (wcnt_q == 8'd0) begin
              // Burst length is set by awlen; a misplaced wlast only flags the response.
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bresp_q  <= (werr_q || !s_axi_wlast) ? 2'b10 : 2'b00;
              wr_st_q  <= WResp;
            end else begin
              wcnt_q <= wcnt_q - 8'd1;
              werr_q <= werr_q | s_axi_wlast;
            end
          end
        end
        WResp: begin
          if (s_axi_bready) begin
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            awready_q <= 1'b1;
            wr_st_q   <= WIdle;
          end
        end
        default: wr_st_q <= WIdle;
      endcase
    end
  end

  // Memory write port; contents are deliberately not reset.
  always_ff @(posedge ACLK) begin
    if (!ARESET && wr_beat) begin
      for (int unsigned b = 0; b < StrbW; b++) begin
        if (s_axi_wstrb[b]) mem_q[widx_q][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  // Read FSM; the fetch sees pre-write data on a same-cycle write to the same word.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rd_st_q   <= RIdle;
      ridx_q    <= '0;
      rcnt_q    <= '0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      unique case (rd_st_q)
        RIdle: begin
          if (s_axi_arvalid) begin
            ridx_q    <= s_axi_araddr[6 +: IdxW];
            rcnt_q    <= s_axi_arlen;
            arready_q <= 1'b0;
            rd_st_q   <= RFetch;
          end
        end
        RFetch: begin
          rdata_q  <= mem_q[ridx_q];
          rvalid_q <= 1'b1;
          rlast_q  <= (rcnt_q == 8'd0);
          rd_st_q  <= RData;
        end
        RData: begin
          if (s_axi_rready) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            if (rlast_q) begin
              arready_q <= 1'b1;
              rd_st_q   <= RIdle;
            end else begin
              ridx_q  <= ridx_q + 1'b1;
              rcnt_q  <= rcnt_q - 8'd1;
              rd_st_q <= RFetch;
            end
          end
        end
        default: rd_st_q <= RIdle;
      endcase
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = 2'b00;
  assign s_axi_rlast   = rlast_q;

endmodule

// File: tb/tb_mvp_axi_mem_slave.sv
`timescale 1ns/1ps
// Scoreboard bench for mvp_axi_mem_slave: a byte-level memory model predicts every read beat.
module tb_mvp_axi_mem_slave;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_axi_awvalid, s_axi_awready;
  logic [63:0]  s_axi_awaddr;
  logic [7:0]   s_axi_awlen;
  logic         s_axi_wvalid, s_axi_wready;
  logic [511:0] s_axi_wdata;
  logic [63:0]  s_axi_wstrb;
  logic         s_axi_wlast;
  logic         s_axi_bvalid, s_axi_bready;
  logic [1:0]   s_axi_bresp;
  logic         s_axi_arvalid, s_axi_arready;
  logic [63:0]  s_axi_araddr;
  logic [7:0]   s_axi_arlen;
  logic         s_axi_rvalid, s_axi_rready;
  logic [511:0] s_axi_rdata;
  logic [1:0]   s_axi_rresp;
  logic         s_axi_rlast;

  int tests_run = 0;
  int failed    = 0;

  logic [511:0] model [1024];
  logic [511:0] wbuf  [256];
  logic [63:0]  sbuf  [256];
  logic         lbuf  [256];
  logic [512:0] exp_q [$];

  always #5 clk = ~clk;

  mvp_axi_mem_slave dut (
    .ACLK          (clk),
    .ARESET        (rst),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awlen   (s_axi_awlen),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wlast   (s_axi_wlast),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arlen   (s_axi_arlen),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rlast   (s_axi_rlast)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] pat(input int unsigned seed);
    logic [511:0] v;
    for (int k = 0; k < 16; k++) v[k*32 +: 32] = seed * 32'h9E37_79B1 + 32'(k);
    return v;
  endfunction

  task automatic fill_beats(input int len, input int unsigned seed);
    for (int i = 0; i <= len; i++) begin
      wbuf[i] = pat(seed + 32'(i));
      sbuf[i] = '1;
      lbuf[i] = (i == len);
    end
  endtask

  // Drives one write burst from wbuf/sbuf/lbuf and updates the model on every accepted beat.
  task automatic axi_write(input logic [63:0] addr, input int len, output logic [1:0] resp);
    int n;
    logic hs;
    logic [9:0] idx;
    resp = 2'bxx;
    s_axi_awaddr = addr; s_axi_awlen = 8'(len); s_axi_awvalid = 1'b1;
    n = 0;
    do begin hs = s_axi_awready; tick(); n++; end while (!hs && n < 100);
    s_axi_awvalid = 1'b0;
    tests_run++;
    if (!hs || s_axi_wready !== 1'b1) begin
      failed++; $display("FAIL aw_to_wready: hs=%b wready=%b want 1", hs, s_axi_wready);
    end
    idx = addr[15:6];
    for (int i = 0; i <= len; i++) begin
      s_axi_wvalid = 1'b1; s_axi_wdata = wbuf[i]; s_axi_wstrb = sbuf[i]; s_axi_wlast = lbuf[i];
      n = 0;
      do begin hs = s_axi_wready; tick(); n++; end while (!hs && n < 100);
      if (!hs) begin
        tests_run++; failed++; $display("FAIL w_timeout: beat %0d never accepted", i);
        break;
      end
      for (int b = 0; b < 64; b++) if (sbuf[i][b]) model[idx][b*8 +: 8] = wbuf[i][b*8 +: 8];
      idx++;
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    tests_run++;
    if (s_axi_bvalid !== 1'b1) begin
      failed++; $display("FAIL w_to_bvalid: got %b want 1", s_axi_bvalid);
    end
    s_axi_bready = 1'b1;
    n = 0;
    do begin hs = s_axi_bvalid; resp = s_axi_bresp; tick(); n++; end while (!hs && n < 100);
    s_axi_bready = 1'b0;
    tests_run++;
    if (!hs || s_axi_awready !== 1'b1 || s_axi_bvalid !== 1'b0) begin
      failed++;
      $display("FAIL b_done: hs=%b awready=%b bvalid=%b want 1,1,0", hs, s_axi_awready,
               s_axi_bvalid);
    end
  endtask

  // Issues a read burst, pushes predicted beats, pops and compares them as the DUT delivers.
  task automatic axi_read(input logic [63:0] addr, input int len, input bit rand_rdy,
                          input int max_beats);
    int n, beats;
    logic hs, stall, plast;
    logic [9:0] idx;
    logic [511:0] pdata;
    logic [512:0] e;
    s_axi_araddr = addr; s_axi_arlen = 8'(len); s_axi_arvalid = 1'b1;
    n = 0;
    do begin hs = s_axi_arready; tick(); n++; end while (!hs && n < 100);
    s_axi_arvalid = 1'b0;
    idx = addr[15:6];
    for (int i = 0; i <= len; i++) begin
      exp_q.push_back({(i == len), model[idx]});
      idx++;
    end
    tests_run++;
    if (!hs || s_axi_rvalid !== 1'b0) begin
      failed++; $display("FAIL ar_t1: hs=%b rvalid=%b want 1,0", hs, s_axi_rvalid);
    end
    tick();
    tests_run++;
    if (s_axi_rvalid !== 1'b1) begin
      failed++; $display("FAIL ar_t2_rvalid: got %b want 1", s_axi_rvalid);
    end
    beats = 0; stall = 1'b0; pdata = '0; plast = 1'b0; n = 0;
    while (beats < max_beats && exp_q.size() > 0 && n < 5000) begin
      s_axi_rready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall && s_axi_rvalid) begin
        tests_run++;
        if (s_axi_rdata !== pdata || s_axi_rlast !== plast) begin
          failed++; $display("FAIL r_hold: rdata/rlast changed while stalled (rlast %b want %b)",
                             s_axi_rlast, plast);
        end
      end
      if (s_axi_rvalid && s_axi_rready) begin
        e = exp_q.pop_front();
        tests_run++;
        if (s_axi_rdata !== e[511:0] || s_axi_rlast !== e[512] || s_axi_rresp !== 2'b00) begin
          failed++;
          $display("FAIL r_beat%0d: rdata=%h rlast=%b rresp=%b want rdata=%h rlast=%b rresp=00",
                   beats, s_axi_rdata[63:0], s_axi_rlast, s_axi_rresp, e[63:0], e[512]);
        end
        tick();
        beats++; stall = 1'b0;
        tests_run++;
        if (s_axi_rvalid !== 1'b0 || (e[512] && s_axi_arready !== 1'b1)) begin
          failed++; $display("FAIL r_after_hs: rvalid=%b arready=%b want 0,%b", s_axi_rvalid,
                             s_axi_arready, e[512]);
        end
      end else begin
        stall = s_axi_rvalid; pdata = s_axi_rdata; plast = s_axi_rlast;
        tick();
      end
      n++;
    end
    s_axi_rready = 1'b0;
    if (n >= 5000) begin
      tests_run++; failed++; $display("FAIL r_timeout: %0d of %0d beats seen", beats, len + 1);
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    s_axi_awvalid = 0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_wvalid = 0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 0; s_axi_bready = 0;
    s_axi_arvalid = 0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_rready = 0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tests_run++;
    if ({s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid, s_axi_rlast}
        !== 6'b110000) begin
      failed++;
      $display("FAIL reset_ctrl: aw/ar/w/b/r/last=%b%b%b%b%b%b want 110000", s_axi_awready,
               s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid, s_axi_rlast);
    end
    tests_run++;
    if (s_axi_bresp !== 2'b00 || s_axi_rresp !== 2'b00 || s_axi_rdata !== '0) begin
      failed++; $display("FAIL reset_data: bresp=%b rresp=%b rdata=%h want 0", s_axi_bresp,
                         s_axi_rresp, s_axi_rdata[63:0]);
    end
    // Data offered before any address must not be accepted.
    s_axi_wvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (s_axi_wready !== 1'b0 || s_axi_awready !== 1'b1) begin
        failed++; $display("FAIL no_buffer: wready=%b awready=%b want 0,1", s_axi_wready,
                           s_axi_awready);
      end
    end
    s_axi_wvalid = 1'b0;
  endtask

  task automatic test_single();
    logic [1:0] r;
    fill_beats(0, 1);
    axi_write(64'h40, 0, r);
    tests_run++;
    if (r !== 2'b00) begin failed++; $display("FAIL single_bresp: got %b want 00", r); end
    axi_read(64'h40, 0, 1'b0, 1);
  endtask

  task automatic test_burst4();
    logic [1:0] r;
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = 512'(i); sbuf[i] = '1; lbuf[i] = (i == 3);
    end
    axi_write(64'h1000, 3, r);
    tests_run++;
    if (r !== 2'b00) begin failed++; $display("FAIL burst4_bresp: got %b want 00", r); end
    axi_read(64'h1000, 3, 1'b1, 4);
  endtask

  task automatic test_strobe();
    logic [1:0] r;
    wbuf[0] = '1; sbuf[0] = '1; lbuf[0] = 1'b1;
    axi_write(64'h2000, 0, r);
    wbuf[0] = '0; sbuf[0] = 64'h0000_0000_0000_000F;
    axi_write(64'h2000, 0, r);
    tests_run++;
    if (r !== 2'b00) begin failed++; $display("FAIL strobe_bresp: got %b want 00", r); end
    tests_run++;
    if (model[128] !== {{480{1'b1}}, 32'h0}) begin
      failed++; $display("FAIL strobe_model: model word not low-4-bytes-zero");
    end
    axi_read(64'h2000, 0, 1'b0, 1);
  endtask

  task automatic test_wrap();
    logic [1:0] r;
    fill_beats(1, 7);
    axi_write(64'hFFC0, 1, r);
    tests_run++;
    if (r !== 2'b00) begin failed++; $display("FAIL wrap_bresp: got %b want 00", r); end
    axi_read(64'h0, 0, 1'b0, 1);
    axi_read(64'hFFC0, 1, 1'b0, 2);
  endtask

  task automatic test_wlast_err();
    logic [1:0] r;
    fill_beats(2, 40);
    lbuf[1] = 1'b1;
    axi_write(64'h3000, 2, r);
    tests_run++;
    if (r !== 2'b10) begin failed++; $display("FAIL wlast_early: bresp %b want 10", r); end
    axi_read(64'h3000, 2, 1'b0, 3);
    fill_beats(0, 50);
    lbuf[0] = 1'b0;
    axi_write(64'h3100, 0, r);
    tests_run++;
    if (r !== 2'b10) begin failed++; $display("FAIL wlast_missing: bresp %b want 10", r); end
    axi_read(64'h3100, 0, 1'b0, 1);
  endtask

  task automatic test_concurrent_reset();
    logic [1:0] r0, r1;
    fill_beats(255, 100);
    axi_write(64'h8000, 255, r0);
    fill_beats(255, 300);
    fork
      axi_write(64'h4000, 255, r1);
      axi_read(64'h8000, 255, 1'b0, 150);
    join
    tests_run++;
    if (r0 !== 2'b00 || r1 !== 2'b00) begin
      failed++; $display("FAIL long_bresp: got %b,%b want 00,00", r0, r1);
    end
    rst = 1'b1;
    tick();
    tests_run++;
    if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b1 || s_axi_awready !== 1'b1) begin
      failed++; $display("FAIL mid_read_reset: rvalid=%b arready=%b awready=%b want 0,1,1",
                         s_axi_rvalid, s_axi_arready, s_axi_awready);
    end
    rst = 1'b0;
    tick();
    axi_read(64'h4000, 7, 1'b1, 8);
    axi_read(64'h8000 + 64'd64 * 64'd250, 5, 1'b0, 6);
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst4();
    test_strobe();
    test_wrap();
    test_wlast_err();
    test_concurrent_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/mvp_axi_mem_slave.md
# mvp_axi_mem_slave

AXI4 burst responder that answers the 512-bit data AXI master port of the MVP accelerator (write-address/data/response and read-address/data channels), backed by an on-chip byte-writable memory. It stands in for the DDR4 controller in on-FPGA loopback tests and simulation, giving deterministic latency so `mvp_top` transfers can be checked without external memory. Read and write channels run independently and concurrently.

## Interface
- AXI_ADDR_WIDTH, 64, byte address width
- AXI_DATA_WIDTH, 512, data width; strobe width is AXI_DATA_WIDTH/8
- MEM_DEPTH, 1024, number of AXI_DATA_WIDTH words; power of two ≥ 2
- ACLK  in  1  single clock for all logic
- ARESET  in  1  synchronous, active-high reset
- s_axi_awvalid / s_axi_awready  in / out  1  write-address handshake
- s_axi_awaddr  in  AXI_ADDR_WIDTH  burst start byte address
- s_axi_awlen  in  8  beats minus one
- s_axi_wvalid / s_axi_wready  in / out  1  write-data handshake
- s_axi_wdata  in  AXI_DATA_WIDTH  write beat
- s_axi_wstrb  in  AXI_DATA_WIDTH/8  byte enables
- s_axi_wlast  in  1  master's last-beat flag
- s_axi_bvalid / s_axi_bready  out / in  1  write-response handshake
- s_axi_bresp  out  2  OKAY 2'b00 or SLVERR 2'b10
- s_axi_arvalid / s_axi_arready  in / out  1  read-address handshake
- s_axi_araddr  in  AXI_ADDR_WIDTH  burst start byte address
- s_axi_arlen  in  8  beats minus one
- s_axi_rvalid / s_axi_rready  out / in  1  read-data handshake
- s_axi_rdata  out  AXI_DATA_WIDTH  read beat
- s_axi_rresp  out  2  always 2'b00
- s_axi_rlast  out  1  last read beat

## Operation
- Burst type INCR only, size fixed to full width; no ID ports (master drives ID 0).
- Word index = addr[6 +: log2(MEM_DEPTH)]; low 6 bits ignored; upper bits ignored (aliasing). Each beat increments the index modulo MEM_DEPTH (wraps to 0).
- Write FSM: W_IDLE (awready=1) → on AW handshake latch index, beat count = awlen → W_DATA (wready=1). Each W handshake writes bytes whose wstrb bit is 1; others unchanged. Termination is by internal count (awlen+1 beats), not wlast. → W_RESP (bvalid=1) → on bready → W_IDLE.
- bresp = SLVERR if wlast was 1 on any non-final beat or 0 on the final beat; else OKAY. Data is still written.
- Read FSM: R_IDLE (arready=1) → on AR handshake latch index, count = arlen → R_FETCH (synchronous memory read issued) → R_DATA (rvalid=1, rdata/rlast held stable until rready). On R handshake: final beat → R_IDLE; else index+1 → R_FETCH.
- rlast = 1 exactly on beat arlen. rresp = 2'b00.
- Same-cycle write and fetch of the same word: fetch returns pre-write data.
- Memory contents not cleared by reset (undefined in simulation until written).

## Timing
- Reset: all FSMs to IDLE; awready=arready=1 from first cycle after reset deasserts; wready, bvalid, rvalid, rlast = 0; bresp, rresp, rdata = 0.
- ARESET mid-burst aborts immediately; partial writes already committed stay; no response issued.
- AW handshake at cycle t → wready=1 at t+1; one beat accepted per cycle while wvalid=1.
- Final W handshake at t → bvalid=1 at t+1; awready=0 from AW handshake until cycle after B handshake.
- AR handshake at t → rvalid=1 at t+2; after non-final R handshake at t, next rvalid at t+2 (throughput one beat per 2 cycles); after final handshake, arready=1 at t+1.
- wvalid before AW handshake: wready stays 0 (no data buffering).
- Holds while valid=1 and ready=0: bvalid/bresp, rvalid/rdata/rlast unchanged.

## Test plan
- Single write awaddr=0x40, awlen=0, wdata=pattern A, wstrb all-ones → bvalid one cycle after W, bresp=00; read araddr=0x40, arlen=0 → rdata=A, rlast=1, rvalid two cycles after AR.
- 4-beat write at 0x1000 with data 0..3, then 4-beat read → rdata 0,1,2,3, rlast only on 4th beat; rready toggled randomly, data held stable while stalled.
- Partial strobe: write all-0xFF, then write 0x00 with wstrb=64'h0000_0000_0000_000F → read returns low 4 bytes 0x00, rest 0xFF.
- Wrap: MEM_DEPTH=1024, write awaddr=0xFFC0 (index 1023), awlen=1 → second beat lands at index 0; read at 0x0 confirms.
- wlast asserted on beat 1 of a 3-beat burst → all 3 beats written, bresp=2'b10.
- Concurrent 256-beat read and 256-beat write to disjoint regions, then ARESET asserted mid-read → rvalid=0, arready=1 next cycle, fresh read after reset completes correctly.
